// File: rtl/alu_pkg.sv
// Shared ALU definitions: command encodings, widths, sequencer state encoding
// and the SLT result fix-up applied to a SUB result.
package alu_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CMD_W = 3;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [CMD_W-1:0] {
    CMD_ADD  = 3'd0,
    CMD_SUB  = 3'd1,
    CMD_XOR  = 3'd2,
    CMD_SLT  = 3'd3,
    CMD_AND  = 3'd4,
    CMD_NAND = 3'd5,
    CMD_NOR  = 3'd6,
    CMD_OR   = 3'd7
  } alu_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_RESPOND = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;
  } alu_flags_t;

  // The ALU has no SLT op; it runs SUB and the signed less-than is sign XOR overflow.
  function automatic logic [CMD_W-1:0] alu_select(input logic [CMD_W-1:0] cmd);
    return (cmd == CMD_SLT) ? CMD_SUB : cmd;
  endfunction

  function automatic alu_flags_t slt_fixup(input alu_flags_t raw);
    alu_flags_t f;
    logic       lt;
    lt         = raw.result[WIDTH-1] ^ raw.overflow;
    f.result   = {{(WIDTH-1){1'b0}}, lt};
    f.carry    = 1'b0;
    f.overflow = 1'b0;
    f.zero     = ~lt;
    return f;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request, response and ALU-facing signals of the ALU sequencer.
interface alu_sequencer_if;
  import alu_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [CMD_W-1:0] req_cmd;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [CMD_W-1:0] alu_selector;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             alu_overflow;
  logic             alu_zero;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carry;
  logic             rsp_overflow;
  logic             rsp_zero;
  logic [CMD_W-1:0] rsp_cmd;

  modport master (
    output req_valid, req_a, req_b, req_cmd, rsp_ready,
           alu_result, alu_carry, alu_overflow, alu_zero,
    input  req_ready, alu_a, alu_b, alu_selector,
           rsp_valid, rsp_result, rsp_carry, rsp_overflow, rsp_zero, rsp_cmd
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cmd, rsp_ready,
           alu_result, alu_carry, alu_overflow, alu_zero,
    output req_ready, alu_a, alu_b, alu_selector,
           rsp_valid, rsp_result, rsp_carry, rsp_overflow, rsp_zero, rsp_cmd
  );

endinterface

// File: rtl/settle_timer.sv
// Loadable down-counter; tc_c flags the last settle cycle (count == 1).
module settle_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             tc_c
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign tc_c = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/alu_sequencer.sv
// Single-outstanding ALU sequencer: drives operands to an external ALU, waits
// SETTLE_CYCLES, captures the result (with SLT fix-up) and hands it back.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned WIDTH         = alu_pkg::WIDTH
) (
  input logic            clk,
  input logic            reset,
  alu_sequencer_if.slave bus
);

  seq_state_e       state_q, state_d;
  logic             accept, capture, rsp_done, tc_c;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CMD_W-1:0] sel_q, cmd_q;
  logic             rsp_valid_q;
  alu_flags_t       rsp_q, alu_raw, rsp_d;

  settle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (CNT_W'(SETTLE_CYCLES)),
    .dec      (state_q == ST_SETTLE),
    .tc_c     (tc_c)
  );

  // Next state and the one-cycle control strobes.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    capture  = 1'b0;
    rsp_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (tc_c) begin
          capture = 1'b1;
          state_d = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        if (bus.rsp_ready) begin
          rsp_done = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    alu_raw.result   = bus.alu_result;
    alu_raw.carry    = bus.alu_carry;
    alu_raw.overflow = bus.alu_overflow;
    alu_raw.zero     = bus.alu_zero;
    rsp_d            = (cmd_q == CMD_SLT) ? slt_fixup(alu_raw) : alu_raw;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= '0;
      cmd_q       <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q   <= bus.req_a;
        b_q   <= bus.req_b;
        cmd_q <= bus.req_cmd;
        sel_q <= alu_select(bus.req_cmd);
      end
      if (capture) begin
        rsp_q       <= rsp_d;
        rsp_valid_q <= 1'b1;
      end else if (rsp_done) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready    = (state_q == ST_IDLE) && !reset;
  assign bus.alu_a        = a_q;
  assign bus.alu_b        = b_q;
  assign bus.alu_selector = sel_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_result   = rsp_q.result;
  assign bus.rsp_carry    = rsp_q.carry;
  assign bus.rsp_overflow = rsp_q.overflow;
  assign bus.rsp_zero     = rsp_q.zero;
  assign bus.rsp_cmd      = cmd_q;

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 4, ALU settle time in clock cycles between driving operands and sampling results; legal range 1..255.
REQ-002 Parameter: WIDTH, default 32, operand/result width; only 32 is supported.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  sequencer can accept a request.
REQ-007 req_a, req_b  in  32 each  operands.
REQ-008 req_cmd  in  3  command: ADD=0, SUB=1, XOR=2, SLT=3, AND=4, NAND=5, NOR=6, OR=7.
REQ-009 alu_a, alu_b  out  32 each  registered operands driven to the ALU.
REQ-010 alu_selector  out  3  registered command driven to the ALU.
REQ-011 alu_result  in  32; alu_carry, alu_overflow, alu_zero  in  1 each  ALU outputs.
REQ-012 rsp_valid  out  1  response present; rsp_ready  in  1  consumer accepts.
REQ-013 rsp_result  out  32; rsp_carry, rsp_overflow, rsp_zero  out  1 each; rsp_cmd  out  3  echo of accepted req_cmd.

Function
REQ-014 FSM states: IDLE, SETTLE, RESPOND; exactly one request in flight.
REQ-015 req_ready SHALL be 1 only in IDLE with reset low; combinational from state.
REQ-016 IDLE: on edge with req_valid=1, latch req_a/req_b into alu_a/alu_b, req_cmd into rsp_cmd, load settle counter with SETTLE_CYCLES, go SETTLE.
REQ-017 alu_selector SHALL be loaded with req_cmd, except SLT loads SUB (1).
REQ-018 SETTLE: counter decrements each edge; on the edge where counter=1, capture ALU outputs into rsp_* registers, set rsp_valid, go RESPOND.
REQ-019 Latency: rsp_valid rises exactly SETTLE_CYCLES edges after the accepting edge.
REQ-020 Non-SLT capture: rsp_result=alu_result, rsp_carry=alu_carry, rsp_overflow=alu_overflow, rsp_zero=alu_zero.
REQ-021 SLT capture: lt=alu_result[31] XOR alu_overflow; rsp_result={31'b0,lt}; rsp_zero=NOT lt; rsp_carry=0; rsp_overflow=0.
REQ-022 RESPOND: all rsp_* and alu_* outputs held stable while rsp_valid=1 and rsp_ready=0.
REQ-023 RESPOND: on edge with rsp_ready=1, clear rsp_valid, go IDLE; next request acceptable no earlier than the following edge.
REQ-024 req_* inputs ignored whenever req_ready=0.
REQ-025 alu_a/alu_b/alu_selector SHALL hold their values after RESPOND until the next acceptance.

Reset
REQ-026 reset=1 at an edge SHALL force, from any state including mid-SETTLE/RESPOND: state IDLE, counter 0, rsp_valid 0, rsp_result 0, all rsp flags 0, rsp_cmd 0, alu_a 0, alu_b 0, alu_selector 0.
REQ-027 A request in flight at reset is discarded; no response is produced for it.
REQ-028 req_ready SHALL be 0 while reset=1.

Structure
REQ-029 Command encodings (REQ-008), WIDTH and the FSM state encoding SHALL live in shared package alu_pkg, also used by the ALU.
REQ-030 The settle counter SHALL be a sub-module settle_timer (load, decrement, terminal-count output, 8-bit).
REQ-031 The ALU is instantiated outside this block; the sequencer contains no arithmetic other than the SLT fix-up.

Verification
REQ-032 ADD a=1,b=1, SETTLE_CYCLES=4 -> rsp_valid exactly 4 edges after acceptance, rsp_result=2, carry=0, overflow=0, zero=0.
REQ-033 SUB a=5,b=5 -> rsp_result=0, rsp_zero=1, rsp_carry=1, rsp_overflow=0.
REQ-034 SLT a=0xFFFFFFFF,b=1 -> alu_selector=1 during SETTLE, rsp_result=1, rsp_zero=0; SLT a=0x7FFFFFFF,b=0x80000000 -> rsp_result=0, rsp_zero=1.
REQ-035 ADD a=0x7FFFFFFF,b=1 -> rsp_result=0x80000000, rsp_overflow=1, rsp_carry=0.
REQ-036 Hold rsp_ready=0 for 10 cycles with req_valid=1 and changing req_* -> rsp_* stable, req_ready=0, no second acceptance; rsp_ready=1 -> rsp_valid 0 next edge, req_ready 1.
REQ-037 Assert reset for one edge during SETTLE -> all outputs at REQ-026 values after that edge, rsp_valid never rises for that request.
